// File: rtl/opora_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opora_pkg
// Description : Shared definitions for the opora (reference coefficient)
//               upload path: coefficient count agreed with the convolution
//               block, header magic, loader FSM state encoding and the
//               err_code values reported on a rejected packet.
// Revision    : 1.0 - initial release
// ============================================================================
package opora_pkg;

    // Coefficients per upload; the convolution block wraps its coefficient
    // counter at this value, so both sides must use this same constant.
    localparam int          NUM_OPORA     = 100;
    localparam logic [15:0] MAGIC_DEFAULT = 16'h4F50;
    localparam int          GAP_DEFAULT   = 0;

    localparam logic [2:0]  c_ERR_NONE  = 3'd0;
    localparam logic [2:0]  c_ERR_MAGIC = 3'd1;
    localparam logic [2:0]  c_ERR_COUNT = 3'd2;
    localparam logic [2:0]  c_ERR_SHORT = 3'd3;
    localparam logic [2:0]  c_ERR_LONG  = 3'd4;
    localparam logic [2:0]  c_ERR_CSUM  = 3'd5;
    localparam logic [2:0]  c_ERR_BUSY  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_CHECK  = 3'd4,
        S_REPLAY = 3'd5,
        S_DROP   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/opora_buf_ram.sv
`default_nettype none
// ============================================================================
// Module      : opora_buf_ram
// Description : DEPTH x DW simple dual-port coefficient buffer. Write port is
//               fed while a packet is being received, the registered read
//               port drives the replay burst. The read register is reset so
//               the coefficient output is 0 out of reset.
// Ports       : clke     - clock
//               rst      - asynchronous active-high reset (read register only)
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable; o_rdata updates on the next edge
//               i_raddr  - read address
//               o_rdata  - registered read data, held when i_re is low
// Revision    : 1.0 - initial release
// ============================================================================
module opora_buf_ram
    import opora_pkg::*;
#(
    parameter int DEPTH = NUM_OPORA,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 16
)(
    input  logic          clke,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clke) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clke or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/opora_loader.sv
`default_nettype none
// ============================================================================
// Module      : opora_loader
// Description : Receives the opora coefficient upload from the Ethernet
//               payload byte stream, checks magic, count, length and
//               checksum, buffers the coefficients and, only for a fully
//               valid packet, replays them as one opora_en/OPORA burst.
// Ports       : clke          - Ethernet-side clock
//               rst           - asynchronous active-high reset
//               i_rx_data     - payload byte
//               i_rx_valid    - byte valid
//               i_rx_sop      - first byte of packet (qualified by valid)
//               i_rx_eop      - last byte of packet (qualified by valid)
//               o_opora_en    - coefficient strobe
//               o_opora       - coefficient value, valid with o_opora_en
//               o_busy        - packet in progress or replay running
//               o_load_done   - pulse with the last strobe of a burst
//               o_err         - pulse on a rejected packet
//               o_err_code    - cause of the last rejection, held
// Revision    : 1.0 - initial release
// ============================================================================
module opora_loader
    import opora_pkg::*;
#(
    parameter int          NUM_OPORA = opora_pkg::NUM_OPORA,
    parameter logic [15:0] MAGIC     = MAGIC_DEFAULT,
    parameter int          GAP       = GAP_DEFAULT
)(
    input  logic        clke,
    input  logic        rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_rx_sop,
    input  logic        i_rx_eop,
    output logic        o_opora_en,
    output logic [15:0] o_opora,
    output logic        o_busy,
    output logic        o_load_done,
    output logic        o_err,
    output logic [2:0]  o_err_code
);

    localparam int IW = (NUM_OPORA > 1) ? $clog2(NUM_OPORA) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [IW-1:0] c_LAST_IDX   = IW'(NUM_OPORA - 1);
    localparam logic [7:0]    c_COUNT_BYTE = 8'(NUM_OPORA);
    localparam logic [GW-1:0] c_GAP        = GW'(GAP);

    state_t          r_state,   w_state_nxt;
    logic [IW-1:0]   r_idx,     w_idx_nxt;
    logic            r_hdr_sel, w_hdr_sel_nxt;   // 0: magic low byte next, 1: count byte next
    logic            r_phase,   w_phase_nxt;     // 0: high byte next, 1: low byte next
    logic [7:0]      r_hi,      w_hi_nxt;
    logic [15:0]     r_sum,     w_sum_nxt;
    logic [15:0]     r_csum,    w_csum_nxt;
    logic [GW-1:0]   r_gap,     w_gap_nxt;

    logic            r_opora_en;
    logic            r_load_done;
    logic            r_err;
    logic [2:0]      r_err_code;

    logic            w_err;
    logic [2:0]      w_err_code;
    logic            w_we;
    logic            w_re;
    logic            w_last;

    logic            w_sop;
    logic            w_eop;
    logic            w_rx_state;
    logic            w_hdr_bad;
    logic [15:0]     w_word;

    assign w_sop  = i_rx_valid & i_rx_sop;
    assign w_eop  = i_rx_valid & i_rx_eop;
    assign w_word = {r_hi, i_rx_data};

    // States in which a sop starts a fresh packet. CHECK ignores input and
    // REPLAY rejects new packets with a busy error instead.
    assign w_rx_state = (r_state != S_CHECK) && (r_state != S_REPLAY);

    assign w_hdr_bad = r_hdr_sel ? (i_rx_data != c_COUNT_BYTE)
                                 : (i_rx_data != MAGIC[7:0]);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clke or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_hdr_sel   <= 1'b0;
            r_phase     <= 1'b0;
            r_hi        <= '0;
            r_sum       <= '0;
            r_csum      <= '0;
            r_gap       <= '0;
            r_opora_en  <= 1'b0;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= c_ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_hdr_sel   <= w_hdr_sel_nxt;
            r_phase     <= w_phase_nxt;
            r_hi        <= w_hi_nxt;
            r_sum       <= w_sum_nxt;
            r_csum      <= w_csum_nxt;
            r_gap       <= w_gap_nxt;
            // The buffer read register presents the word on the same edge
            // that raises the strobe.
            r_opora_en  <= w_re;
            r_load_done <= w_re & w_last;
            r_err       <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_hdr_sel_nxt = r_hdr_sel;
        w_phase_nxt   = r_phase;
        w_hi_nxt      = r_hi;
        w_sum_nxt     = r_sum;
        w_csum_nxt    = r_csum;
        w_gap_nxt     = r_gap;
        w_err         = 1'b0;
        w_err_code    = c_ERR_NONE;
        w_we          = 1'b0;
        w_re          = 1'b0;
        w_last        = 1'b0;

        if (w_sop && w_rx_state) begin
            // A sop always restarts reception; the sop byte is magic high.
            w_idx_nxt     = '0;
            w_sum_nxt     = '0;
            w_phase_nxt   = 1'b0;
            w_hdr_sel_nxt = 1'b0;
            if (i_rx_data != MAGIC[15:8]) begin
                w_err       = 1'b1;
                w_err_code  = c_ERR_MAGIC;
                w_state_nxt = i_rx_eop ? S_IDLE : S_DROP;
            end else if (i_rx_eop) begin
                w_err       = 1'b1;
                w_err_code  = c_ERR_SHORT;
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = S_HDR;
            end
        end else begin
            case (r_state)
                S_HDR: begin
                    if (i_rx_valid) begin
                        if (w_hdr_bad) begin
                            w_err       = 1'b1;
                            w_err_code  = r_hdr_sel ? c_ERR_COUNT : c_ERR_MAGIC;
                            w_state_nxt = i_rx_eop ? S_IDLE : S_DROP;
                        end else if (i_rx_eop) begin
                            w_err       = 1'b1;
                            w_err_code  = c_ERR_SHORT;
                            w_state_nxt = S_IDLE;
                        end else if (!r_hdr_sel) begin
                            w_hdr_sel_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (i_rx_valid) begin
                        if (i_rx_eop) begin
                            w_err       = 1'b1;
                            w_err_code  = c_ERR_SHORT;
                            w_state_nxt = S_IDLE;
                        end else if (!r_phase) begin
                            w_hi_nxt    = i_rx_data;
                            w_phase_nxt = 1'b1;
                        end else begin
                            w_we        = 1'b1;
                            w_sum_nxt   = r_sum + w_word;
                            w_phase_nxt = 1'b0;
                            if (r_idx == c_LAST_IDX) begin
                                w_idx_nxt   = '0;
                                w_state_nxt = S_CSUM;
                            end else begin
                                w_idx_nxt = r_idx + 1'b1;
                            end
                        end
                    end
                end

                S_CSUM: begin
                    if (i_rx_valid) begin
                        if (!r_phase) begin
                            if (i_rx_eop) begin
                                w_err       = 1'b1;
                                w_err_code  = c_ERR_SHORT;
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_hi_nxt    = i_rx_data;
                                w_phase_nxt = 1'b1;
                            end
                        end else begin
                            w_csum_nxt  = w_word;
                            w_phase_nxt = 1'b0;
                            if (i_rx_eop) begin
                                w_state_nxt = S_CHECK;
                            end else begin
                                w_err       = 1'b1;
                                w_err_code  = c_ERR_LONG;
                                w_state_nxt = S_DROP;
                            end
                        end
                    end
                end

                S_CHECK: begin
                    if (r_sum == r_csum) begin
                        w_idx_nxt   = '0;
                        w_gap_nxt   = '0;
                        w_state_nxt = S_REPLAY;
                    end else begin
                        w_err       = 1'b1;
                        w_err_code  = c_ERR_CSUM;
                        w_state_nxt = S_IDLE;
                    end
                end

                S_REPLAY: begin
                    if (w_sop) begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_BUSY;
                    end
                    if (r_gap == '0) begin
                        w_re      = 1'b1;
                        w_gap_nxt = c_GAP;
                        if (r_idx == c_LAST_IDX) begin
                            w_last      = 1'b1;
                            w_idx_nxt   = '0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_gap_nxt = r_gap - 1'b1;
                    end
                end

                S_DROP: begin
                    if (w_eop) begin
                        w_state_nxt = S_IDLE;
                    end
                end

                default: begin
                    // S_IDLE: only a sop (handled above) leaves idle.
                end
            endcase
        end
    end

    opora_buf_ram #(
        .DEPTH (NUM_OPORA),
        .AW    (IW),
        .DW    (16)
    ) u_buf (
        .clke    (clke),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (w_word),
        .i_re    (w_re),
        .i_raddr (r_idx),
        .o_rdata (o_opora)
    );

    assign o_opora_en  = r_opora_en;
    assign o_busy      = (r_state != S_IDLE);
    assign o_load_done = r_load_done;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_opora_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_opora_loader
// Description : Self-checking bench for opora_loader. Directed packet table,
//               hand-written multi-cycle sequences (replay busy, reset during
//               burst, sop mid-packet) and randomized packets judged by a
//               byte-level packet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opora_loader;
    import opora_pkg::*;

    localparam int N       = NUM_OPORA;
    localparam int TB_GAP  = 0;
    localparam int PKT_LEN = 3 + 2 * N + 2;

    localparam int K_VALID    = 0;
    localparam int K_BADSUM   = 1;
    localparam int K_SHORT    = 2;
    localparam int K_LONG     = 3;
    localparam int K_BADMAGIC = 4;
    localparam int K_BADCNT   = 5;

    logic        clke = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sop;
    logic        rx_eop;
    logic        opora_en;
    logic [15:0] opora;
    logic        busy;
    logic        load_done;
    logic        err;
    logic [2:0]  err_code;

    opora_loader #(
        .NUM_OPORA (N),
        .MAGIC     (16'h4F50),
        .GAP       (TB_GAP)
    ) dut (
        .clke        (clke),
        .rst         (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_rx_sop    (rx_sop),
        .i_rx_eop    (rx_eop),
        .o_opora_en  (opora_en),
        .o_opora     (opora),
        .o_busy      (busy),
        .o_load_done (load_done),
        .o_err       (err),
        .o_err_code  (err_code)
    );

    always #5 clke = ~clke;

    int cyc = 0;
    always @(posedge clke) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    logic [15:0] mon_word[$];
    int          mon_cyc[$];
    bit          mon_ld[$];
    logic [2:0]  mon_err[$];
    int          mon_orphan = 0;

    always @(negedge clke) begin
        if (opora_en) begin
            mon_word.push_back(opora);
            mon_cyc.push_back(cyc);
            mon_ld.push_back(load_done);
        end else if (load_done) begin
            mon_orphan <= mon_orphan + 1;
        end
        if (err) mon_err.push_back(err_code);
    end

    int          n_pass  = 0;
    int          n_total = 0;
    logic [7:0]  pkt[$];
    logic [15:0] exp_words[$];
    logic [15:0] saved_words[$];
    int          last_cyc;
    int          base_s, base_e, base_o;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] base;
        int          trunc;
        int          exp_code;
        int          exp_n;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic build(input int kind, input bit rnd, input logic [15:0] base, input int trunc_len);
        logic [15:0] sum;
        logic [15:0] w;
        sum = '0;
        pkt.delete();
        exp_words.delete();
        pkt.push_back(8'h4F);
        pkt.push_back((kind == K_BADMAGIC) ? 8'h51 : 8'h50);
        pkt.push_back((kind == K_BADCNT) ? 8'(N - 1) : 8'(N));
        for (int k = 0; k < N; k++) begin
            w = rnd ? 16'($urandom) : (base + 16'(k));
            exp_words.push_back(w);
            sum = sum + w;
            pkt.push_back(w[15:8]);
            pkt.push_back(w[7:0]);
        end
        if (kind == K_BADSUM) sum = sum + 16'd1;
        pkt.push_back(sum[15:8]);
        pkt.push_back(sum[7:0]);
        if (kind == K_LONG) begin
            pkt.push_back(8'($urandom));
            pkt.push_back(8'($urandom));
        end
        if (kind == K_SHORT) begin
            while (pkt.size() > trunc_len) void'(pkt.pop_back());
        end
    endtask

    // Expected err_code for the packet in pkt, sent while the loader is idle
    // (0 = accepted and replayed).
    function automatic int model_code();
        int          len;
        logic [15:0] s;
        logic [15:0] rxs;
        len = pkt.size();
        s   = '0;
        if (pkt[0] != 8'h4F) return 1;
        if (len > 1 && pkt[1] != 8'h50) return 1;
        if (len > 2 && pkt[2] != 8'(N)) return 2;
        if (len < PKT_LEN) return 3;
        if (len > PKT_LEN) return 4;
        for (int k = 0; k < N; k++) s = s + {pkt[3 + 2 * k], pkt[4 + 2 * k]};
        rxs = {pkt[PKT_LEN - 2], pkt[PKT_LEN - 1]};
        return (s == rxs) ? 0 : 5;
    endfunction

    task automatic send(input int nbytes, input int gap_max);
        for (int i = 0; i < nbytes; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            rx_valid = 1'b0;
            rx_sop   = 1'b0;
            rx_eop   = 1'b0;
            repeat (g) @(negedge clke);
            rx_valid = 1'b1;
            rx_data  = pkt[i];
            rx_sop   = (i == 0);
            rx_eop   = (i == pkt.size() - 1);
            last_cyc = cyc;
            @(negedge clke);
        end
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
    endtask

    task automatic wait_quiet();
        int idle;
        int t;
        idle = 0;
        t    = 0;
        while (idle < 6 && t < 3000) begin
            @(negedge clke);
            t++;
            if (!busy && !opora_en) idle++;
            else idle = 0;
        end
        if (t >= 3000) chk("quiesce_timeout", t, 0);
    endtask

    task automatic wait_strobes(input int n);
        int t;
        t = 0;
        while ((mon_word.size() - base_s) < n && t < 1000) begin
            @(negedge clke);
            t++;
        end
        if (t >= 1000) chk("strobe_wait_timeout", mon_word.size() - base_s, n);
    endtask

    task automatic mark();
        base_s = mon_word.size();
        base_e = mon_err.size();
        base_o = mon_orphan;
    endtask

    task automatic check_result(input string name, input int exp_code, input int exp_n, input int t_last);
        int n;
        int ne;
        n  = mon_word.size() - base_s;
        ne = mon_err.size() - base_e;
        chk({name, "_err_count"}, ne, (exp_code != 0) ? 1 : 0);
        if (exp_code != 0 && ne > 0) begin
            chk({name, "_err_code"}, mon_err[base_e], exp_code);
            chk({name, "_err_code_held"}, err_code, exp_code);
        end
        chk({name, "_strobes"}, n, exp_n);
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_ld_orphan"}, mon_orphan - base_o, 0);
        if (exp_n > 0 && n == exp_n) begin
            int bad_w;
            int bad_c;
            int ld_cnt;
            bad_w  = 0;
            bad_c  = 0;
            ld_cnt = 0;
            for (int k = 0; k < n; k++) begin
                if (mon_word[base_s + k] != exp_words[k]) bad_w++;
                if (mon_cyc[base_s + k] != mon_cyc[base_s] + k * (TB_GAP + 1)) bad_c++;
                if (mon_ld[base_s + k]) ld_cnt++;
            end
            chk({name, "_latency"}, mon_cyc[base_s] - t_last, 3);
            chk({name, "_words_bad"}, bad_w, 0);
            chk({name, "_spacing_bad"}, bad_c, 0);
            chk({name, "_ld_count"}, ld_cnt, 1);
            chk({name, "_ld_on_last"}, mon_ld[base_s + n - 1], 1);
        end
    endtask

    initial begin
        int t_first;
        int code;
        int kind;

        vecs[0] = '{"valid",     K_VALID,    16'h0100, 0,   0, N};
        vecs[1] = '{"bad_csum",  K_BADSUM,   16'h0100, 0,   5, 0};
        vecs[2] = '{"short150",  K_SHORT,    16'h0200, 150, 3, 0};
        vecs[3] = '{"long",      K_LONG,     16'h0300, 0,   4, 0};
        vecs[4] = '{"bad_magic", K_BADMAGIC, 16'h0400, 0,   1, 0};
        vecs[5] = '{"bad_count", K_BADCNT,   16'h0500, 0,   2, 0};

        rst      = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
        repeat (3) @(negedge clke);
        chk("reset_opora_en", opora_en, 0);
        chk("reset_opora", opora, 0);
        chk("reset_busy", busy, 0);
        chk("reset_load_done", load_done, 0);
        chk("reset_err", err, 0);
        chk("reset_err_code", err_code, 0);
        rst = 1'b0;
        repeat (2) @(negedge clke);

        // Directed packet table
        for (int i = 0; i < 6; i++) begin
            build(vecs[i].kind, 1'b0, vecs[i].base, vecs[i].trunc);
            mark();
            send(pkt.size(), 0);
            wait_quiet();
            check_result(vecs[i].name, vecs[i].exp_code, vecs[i].exp_n, last_cyc);
        end

        // Second packet arrives while the first is being replayed
        build(K_VALID, 1'b1, 16'h0, 0);
        saved_words = exp_words;
        mark();
        send(pkt.size(), 0);
        t_first = last_cyc;
        wait_strobes(10);
        build(K_VALID, 1'b1, 16'h0, 0);
        send(pkt.size(), 0);
        wait_quiet();
        exp_words = saved_words;
        check_result("replay_busy", 6, N, t_first);

        // Reset at the 40th strobe, then a clean burst
        build(K_VALID, 1'b1, 16'h0, 0);
        mark();
        send(pkt.size(), 0);
        wait_strobes(40);
        rst = 1'b1;
        #1;
        chk("midrst_opora_en", opora_en, 0);
        chk("midrst_opora", opora, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_load_done", load_done, 0);
        chk("midrst_err_code", err_code, 0);
        @(negedge clke);
        rst = 1'b0;
        @(negedge clke);
        build(K_VALID, 1'b0, 16'hA000, 0);
        mark();
        send(pkt.size(), 0);
        wait_quiet();
        check_result("after_reset", 0, N, last_cyc);

        // sop re-asserted in the middle of the data words
        build(K_VALID, 1'b1, 16'h0, 0);
        mark();
        send(23, 0);
        build(K_VALID, 1'b0, 16'h3000, 0);
        send(pkt.size(), 1);
        wait_quiet();
        check_result("sop_mid_data", 0, N, last_cyc);

        // Randomized packets against the packet model
        for (int r = 0; r < 10; r++) begin
            kind = int'($urandom_range(5, 0));
            build(kind, 1'b1, 16'h0, int'($urandom_range(PKT_LEN - 1, 1)));
            code = model_code();
            mark();
            send(pkt.size(), 2);
            wait_quiet();
            check_result("rand", code, (code == 0) ? N : 0, last_cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
